// File: rtl/lsu_read_master.sv
// Load-side master for the single-beat read bus.
// It runs the address and data handshakes, extracts and extends the addressed field, and flags misalignment or timeout.
module lsu_read_master #(
  parameter int BITS_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BITS_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic              req_signed,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [BITS_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic [BITS_W-1:0] MEM_raddr,
  output logic [2:0]        MEM_rsize,
  output logic              MEM_raddr_valid,
  input  logic              MEM_raddr_ready,
  input  logic [BITS_W-1:0] MEM_rdata,
  input  logic              MEM_rdata_valid,
  output logic              MEM_rdata_ready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t            state;
  logic [4:0]        flags;
  logic              signed_q;
  logic [15:0]       tmo_cnt;
  logic              req_bad;
  logic              tmo_hit;
  logic [BITS_W-1:0] shifted;
  logic [BITS_W-1:0] extracted;

  // Handshake outputs are a pure function of the state being entered: {req_ready, busy, raddr_valid, rdata_ready, resp_valid}
  function automatic logic [4:0] decode(input state_t s);
    case (s)
      IDLE:    decode = 5'b10000;
      ADDR:    decode = 5'b01100;
      DATA:    decode = 5'b01010;
      RESP:    decode = 5'b01001;
      default: decode = 5'b10000;
    endcase
  endfunction

  assign {req_ready, busy, MEM_raddr_valid, MEM_rdata_ready, resp_valid} = flags;

  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      3'd0:    req_bad = 1'b0;
      3'd1:    req_bad = req_addr[0];
      3'd2:    req_bad = |req_addr[1:0];
      3'd3:    req_bad = |req_addr[2:0];
      default: req_bad = 1'b1;
    endcase
  end

  // The counter spans both bus phases, so the abort fires on the last cycle that is still allowed
  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign shifted = MEM_rdata >> {MEM_raddr[2:0], 3'b000};

  always_comb begin
    extracted = shifted;
    case (MEM_rsize[1:0])
      2'd0:    extracted = {{(BITS_W-8){signed_q & shifted[7]}}, shifted[7:0]};
      2'd1:    extracted = {{(BITS_W-16){signed_q & shifted[15]}}, shifted[15:0]};
      2'd2:    extracted = {{(BITS_W-32){signed_q & shifted[31]}}, shifted[31:0]};
      default: extracted = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flags     <= decode(IDLE);
      MEM_raddr <= '0;
      MEM_rsize <= '0;
      signed_q  <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            MEM_raddr <= req_addr;
            MEM_rsize <= req_size;
            signed_q  <= req_signed;
            tmo_cnt   <= '0;
            if (req_bad) begin
              state     <= RESP;
              flags     <= decode(RESP);
              resp_data <= '0;
              resp_err  <= 1'b1;
            end else begin
              state <= ADDR;
              flags <= decode(ADDR);
            end
          end
        end
        ADDR: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (MEM_raddr_ready) begin
            state <= DATA;
            flags <= decode(DATA);
          end else if (tmo_hit) begin
            state     <= RESP;
            flags     <= decode(RESP);
            resp_data <= '0;
            resp_err  <= 1'b1;
          end
        end
        DATA: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (MEM_rdata_valid) begin
            state     <= RESP;
            flags     <= decode(RESP);
            resp_data <= extracted;
            resp_err  <= 1'b0;
          end else if (tmo_hit) begin
            state     <= RESP;
            flags     <= decode(RESP);
            resp_data <= '0;
            resp_err  <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state <= IDLE;
            flags <= decode(IDLE);
          end
        end
        default: begin
          state <= IDLE;
          flags <= decode(IDLE);
        end
      endcase
    end
  end

endmodule
